// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between a sprite requester and the sprite plotter.
//   req, item, erase, position : request from the master
//   ready                      : plotter can take a request
//   x, y, colour, plot         : pixel write towards vga_adapter
//   done                       : one-cycle completion pulse
interface sprite_plotter_if;
    logic       req;
    logic       item;
    logic       erase;
    logic [2:0] position;
    logic       ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    modport master (
        output req, item, erase, position,
        input  ready, x, y, colour, plot, done
    );

    modport slave (
        input  req, item, erase, position,
        output ready, x, y, colour, plot, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Sprite plotter: draws a garbage (20x20) or press (40x60) sprite into the
// VGA frame buffer one pixel per cycle, with a one-entry pending slot.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : sprite_plotter_if.slave (request in, pixel stream / done out)
module sprite_plotter #(
    parameter logic [2:0] GARB_COLOUR  = 3'b010,
    parameter logic [2:0] PRESS_COLOUR = 3'b111
) (
    input  logic            clock,
    input  logic            reset,
    sprite_plotter_if.slave bus
);

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned COL_W = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PLOT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             pend_full_q, pend_full_d;
    logic             pend_item_q, pend_item_d;
    logic             pend_erase_q, pend_erase_d;
    logic [2:0]       pend_pos_q, pend_pos_d;
    logic             cur_item_q, cur_item_d;
    logic             cur_erase_q, cur_erase_d;
    logic [2:0]       cur_pos_q, cur_pos_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [Y_W-1:0]   y0_q, y0_d;
    logic [CNT_W-1:0] w_last_q, w_last_d;
    logic [CNT_W-1:0] h_last_q, h_last_d;
    logic [COL_W-1:0] spr_col_q, spr_col_d;
    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [COL_W-1:0] colour_q, colour_d;
    logic             plot_q, plot_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             accept_c;
    logic             geom_ok;

    assign accept_c = bus.req & ready_q;

    // Next-state, pending-slot and pixel-output logic.
    always_comb begin
        state_d      = state_q;
        pend_full_d  = pend_full_q;
        pend_item_d  = pend_item_q;
        pend_erase_d = pend_erase_q;
        pend_pos_d   = pend_pos_q;
        cur_item_d   = cur_item_q;
        cur_erase_d  = cur_erase_q;
        cur_pos_d    = cur_pos_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        w_last_d     = w_last_q;
        h_last_d     = h_last_q;
        spr_col_d    = spr_col_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        geom_ok      = 1'b0;

        // Requests arriving while busy go to the pending slot.
        if (accept_c && (state_q == LOAD || state_q == PLOT)) begin
            pend_full_d  = 1'b1;
            pend_item_d  = bus.item;
            pend_erase_d = bus.erase;
            pend_pos_d   = bus.position;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cur_item_d  = bus.item;
                    cur_erase_d = bus.erase;
                    cur_pos_d   = bus.position;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (!cur_item_q) begin
                    geom_ok   = (cur_pos_q <= 3'd3);
                    x0_d      = 8'd10 + 8'(cur_pos_q[1:0]) * 8'd40;
                    y0_d      = 7'd90;
                    w_last_d  = 6'd19;
                    h_last_d  = 6'd19;
                    spr_col_d = GARB_COLOUR;
                end else begin
                    geom_ok = (cur_pos_q <= 3'd5);
                    case (cur_pos_q)
                        3'd1, 3'd5: x0_d = 8'd40;
                        3'd2, 3'd4: x0_d = 8'd80;
                        3'd3:       x0_d = 8'd120;
                        default:    x0_d = 8'd0;
                    endcase
                    y0_d      = 7'd20;
                    w_last_d  = 6'd39;
                    h_last_d  = 6'd59;
                    spr_col_d = PRESS_COLOUR;
                end
                if (cur_erase_q) spr_col_d = 3'b000;
                cx_d    = '0;
                cy_d    = '0;
                state_d = geom_ok ? PLOT : DONE;
            end
            PLOT: begin
                x_d      = x0_q + 8'(cx_q);
                y_d      = y0_q + 7'(cy_q);
                colour_d = spr_col_q;
                plot_d   = 1'b1;
                if (cx_q == w_last_q) begin
                    cx_d = '0;
                    if (cy_q == h_last_q) state_d = DONE;
                    else                  cy_d    = cy_q + 6'd1;
                end else begin
                    cx_d = cx_q + 6'd1;
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (pend_full_q) begin
                    cur_item_d  = pend_item_q;
                    cur_erase_d = pend_erase_q;
                    cur_pos_d   = pend_pos_q;
                    pend_full_d = 1'b0;
                    state_d     = LOAD;
                end else if (accept_c) begin
                    cur_item_d  = bus.item;
                    cur_erase_d = bus.erase;
                    cur_pos_d   = bus.position;
                    state_d     = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = ~pend_full_d;
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_full_q  <= 1'b0;
            pend_item_q  <= 1'b0;
            pend_erase_q <= 1'b0;
            pend_pos_q   <= '0;
            cur_item_q   <= 1'b0;
            cur_erase_q  <= 1'b0;
            cur_pos_q    <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            w_last_q     <= '0;
            h_last_q     <= '0;
            spr_col_q    <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_full_q  <= pend_full_d;
            pend_item_q  <= pend_item_d;
            pend_erase_q <= pend_erase_d;
            pend_pos_q   <= pend_pos_d;
            cur_item_q   <= cur_item_d;
            cur_erase_q  <= cur_erase_d;
            cur_pos_q    <= cur_pos_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_last_q     <= w_last_d;
            h_last_q     <= h_last_d;
            spr_col_q    <= spr_col_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed testbench for sprite_plotter: pixel stream monitor with an
// expected raster-order model, latency and queueing checks.
module tb_sprite_plotter;

    logic clock;
    logic reset;
    sprite_plotter_if bus();

    sprite_plotter #(
        .GARB_COLOUR (3'b010),
        .PRESS_COLOUR(3'b111)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (sampled on the falling edge, cyc = rising edges so far).
    int cyc = 0;
    int pix, ix, iy, min_x, max_x, min_y, max_y, bad_col, order_err;
    int first_cyc, last_cyc, done_cnt, done_cyc;
    int m_x0, m_y0, m_w;
    int m_col;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic clear_mon(input int x0, input int y0, input int w, input int col);
        pix = 0; ix = 0; iy = 0;
        min_x = 999; max_x = -1; min_y = 999; max_y = -1;
        bad_col = 0; order_err = 0;
        first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
        m_x0 = x0; m_y0 = y0; m_w = w; m_col = col;
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        if (bus.plot) begin
            if (pix == 0) first_cyc = cyc;
            last_cyc = cyc;
            pix++;
            if (int'(bus.x) < min_x) min_x = int'(bus.x);
            if (int'(bus.x) > max_x) max_x = int'(bus.x);
            if (int'(bus.y) < min_y) min_y = int'(bus.y);
            if (int'(bus.y) > max_y) max_y = int'(bus.y);
            if (int'(bus.colour) != m_col) bad_col++;
            if (int'(bus.x) != m_x0 + ix || int'(bus.y) != m_y0 + iy) order_err++;
            ix++;
            if (ix == m_w) begin
                ix = 0;
                iy++;
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Present a request for one rising edge; n is that edge's index.
    task automatic send(input logic it, input logic er, input logic [2:0] pos, output int n);
        bus.req      = 1'b1;
        bus.item     = it;
        bus.erase    = er;
        bus.position = pos;
        tick();
        n = cyc;
        bus.req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n, n2, n3, d1, guard;
        reset        = 1'b1;
        bus.req      = 1'b0;
        bus.item     = 1'b0;
        bus.erase    = 1'b0;
        bus.position = 3'd0;
        clear_mon(0, 0, 1, 0);
        repeat (3) tick();

        // Reset values.
        check("rst_ready", int'(bus.ready), 1);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        reset = 1'b0;
        tick();

        // Garbage, position 2.
        clear_mon(90, 90, 20, 3'b010);
        send(1'b0, 1'b0, 3'd2, n);
        wait_done("garb2", 500);
        check("garb2_pix", pix, 400);
        check("garb2_minx", min_x, 90);
        check("garb2_maxx", max_x, 109);
        check("garb2_miny", min_y, 90);
        check("garb2_maxy", max_y, 109);
        check("garb2_col", bad_col, 0);
        check("garb2_order", order_err, 0);
        check("garb2_first", first_cyc - n, 2);
        check("garb2_last", last_cyc - n, 401);
        check("garb2_done", done_cyc - n, 402);
        tick();
        check("garb2_done_1cyc", int'(bus.done), 0);
        check("garb2_hold_x", int'(bus.x), 109);
        check("garb2_hold_y", int'(bus.y), 109);
        check("garb2_hold_col", int'(bus.colour), 2);

        // Press erase, position 4.
        clear_mon(80, 20, 40, 3'b000);
        send(1'b1, 1'b1, 3'd4, n);
        wait_done("press4", 2600);
        check("press4_pix", pix, 2400);
        check("press4_minx", min_x, 80);
        check("press4_maxx", max_x, 119);
        check("press4_miny", min_y, 20);
        check("press4_maxy", max_y, 79);
        check("press4_col", bad_col, 0);
        check("press4_order", order_err, 0);
        check("press4_first", first_cyc - n, 2);
        check("press4_done", done_cyc - n, 2402);
        tick();

        // Queueing: second request pending, third ignored.
        clear_mon(10, 90, 20, 3'b010);
        send(1'b0, 1'b0, 3'd0, n);
        repeat (50) tick();
        check("q_ready_before", int'(bus.ready), 1);
        send(1'b1, 1'b0, 3'd5, n2);
        check("q_ready_full", int'(bus.ready), 0);
        repeat (5) tick();
        send(1'b0, 1'b0, 3'd1, n3);
        check("q_ready_still", int'(bus.ready), 0);
        wait_done("q_first", 500);
        check("q_first_pix", pix, 400);
        check("q_first_order", order_err, 0);
        check("q_first_done", done_cyc - n, 402);
        check("q_ready_back", int'(bus.ready), 1);
        d1 = done_cyc;
        clear_mon(40, 20, 40, 3'b111);
        wait_done("q_second", 2600);
        check("q_second_first", first_cyc - d1, 2);
        check("q_second_pix", pix, 2400);
        check("q_second_order", order_err, 0);
        check("q_second_col", bad_col, 0);
        check("q_second_done", done_cyc - d1, 2402);
        repeat (30) tick();
        check("q_third_ignored_done", done_cnt, 1);
        check("q_third_ignored_pix", pix, 2400);

        // Invalid positions: no pixels, done two edges after acceptance.
        clear_mon(0, 0, 1, 0);
        send(1'b0, 1'b0, 3'd5, n);
        wait_done("inv_garb", 20);
        check("inv_garb_pix", pix, 0);
        check("inv_garb_done", done_cyc - n, 2);
        tick();
        clear_mon(0, 0, 1, 0);
        send(1'b1, 1'b0, 3'd6, n);
        wait_done("inv_press", 20);
        check("inv_press_pix", pix, 0);
        check("inv_press_done", done_cyc - n, 2);
        tick();

        // Reset at the 100th press pixel, with a request pending.
        clear_mon(0, 20, 40, 3'b111);
        send(1'b1, 1'b0, 3'd0, n);
        repeat (10) tick();
        send(1'b0, 1'b0, 3'd1, n2);
        guard = 0;
        while (pix < 100 && guard < 300) begin
            tick();
            guard++;
        end
        check("mid_reach100", pix, 100);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_plot", int'(bus.plot), 0);
        check("mid_rst_ready", int'(bus.ready), 1);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_x", int'(bus.x), 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("mid_no_more_pix", pix, 100);
        check("mid_no_done", done_cnt, 0);

        clear_mon(130, 90, 20, 3'b010);
        send(1'b0, 1'b0, 3'd3, n);
        wait_done("post_rst", 500);
        check("post_rst_pix", pix, 400);
        check("post_rst_first", first_cyc - n, 2);
        check("post_rst_done", done_cyc - n, 402);
        check("post_rst_order", order_err, 0);
        check("post_rst_minx", min_x, 130);
        check("post_rst_maxx", max_x, 149);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 The block SHALL have parameter GARB_COLOUR, default 3'b010, colour of garbage sprite pixels.
REQ-002 The block SHALL have parameter PRESS_COLOUR, default 3'b111, colour of press sprite pixels.
REQ-003 The block SHALL have port clock  input  1  single clock for all state, rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req  input  1  draw request, sampled on a rising clock edge.
REQ-006 The block SHALL have port item  input  1  sprite select: 0 = garbage, 1 = press.
REQ-007 The block SHALL have port erase  input  1  1 = plot colour 3'b000 instead of the sprite colour.
REQ-008 The block SHALL have port position  input  3  sprite slot index.
REQ-009 The block SHALL have port ready  output  1  high when a request can be accepted (pending slot empty).
REQ-010 The block SHALL have port x  output  8  pixel column to vga_adapter.
REQ-011 The block SHALL have port y  output  7  pixel row to vga_adapter.
REQ-012 The block SHALL have port colour  output  3  pixel colour to vga_adapter.
REQ-013 The block SHALL have port plot  output  1  pixel write strobe to vga_adapter.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse when a request completes.

Function
REQ-015 A request SHALL be accepted on an edge where req=1 and ready=1; item, erase and position SHALL be captured at that edge.
REQ-016 The FSM SHALL have states IDLE, LOAD, PLOT and DONE.
REQ-017 IDLE->LOAD on an accepted request; LOAD computes origin, size and colour in one cycle, then ->PLOT.
REQ-018 PLOT SHALL emit one pixel per cycle with plot=1, in raster order (x increments fastest, then y), ->DONE after the last pixel.
REQ-019 DONE SHALL assert done for exactly one cycle with plot=0.
REQ-020 Garbage (item=0) SHALL be 20x20 at x0=10+40*position, y0=90, for position 0..3.
REQ-021 Press (item=1) SHALL be 40x60 at y0=20 and x0 = 0, 40, 80, 120, 80, 40 for position 0..5.
REQ-022 An invalid position (garbage >3, press >5) SHALL be accepted, plot no pixels, and go LOAD->DONE.
REQ-023 Latency: for a request accepted at edge N, the first plot SHALL be at N+2, the last garbage pixel at N+401 (press N+2401), and done at N+402 (press N+2402).
REQ-024 A request accepted while not in IDLE SHALL be held in a one-entry pending slot; ready SHALL be 0 while the slot is full.
REQ-025 req while ready=0 SHALL be ignored and not queued.
REQ-026 From DONE, the next state SHALL be LOAD with the pending slot contents if the slot is full, else LOAD with a request accepted in that cycle, else IDLE.
REQ-027 When the slot drains into LOAD, ready SHALL return to 1 on the following cycle.
REQ-028 x, y and colour SHALL hold their last value whenever plot=0.
REQ-029 Pixel counters SHALL be sized so that no coordinate exceeds 159 (x) or 119 (y); no wrap-around SHALL occur for valid positions.

Reset
REQ-030 Reset SHALL asynchronously force state=IDLE, pending slot empty, ready=1, plot=0, done=0, x=0, y=0, colour=0.
REQ-031 Reset asserted mid-PLOT SHALL abandon the sprite with no further pixels and no done pulse; the pending request SHALL be discarded.
REQ-032 After reset deassertion, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-033 Garbage item=0, erase=0, position=2 -> exactly 400 plots, x 90..109, y 90..109, colour 3'b010; done at N+402.
REQ-034 Press item=1, erase=1, position=4 -> 2400 plots, x 80..119, y 20..79, colour 3'b000; done at N+2402.
REQ-035 Second req (press, position 5) mid-garbage, then a third req -> the second is queued with ready=0, the third is ignored, the second's LOAD follows done with no idle gap.
REQ-036 Garbage position=5 -> zero plots; done pulses at N+2.
REQ-037 Reset asserted at the 100th pixel of a press -> plot=0 immediately, no done, ready=1; a new request afterwards completes normally.
